cla_sub_pipe: RTL and testbench
===============================

// Module: cla_sub_pipe
// PURPOSE
//  Two-stage pipelined subtractor: D = A - B - borrowIn, computed as A + ~B + ~borrowIn.
//  Built from 4-bit carry-lookahead slices with group P/G chaining.
//  Stage 1 resolves the low half; stage 2 resolves the high half and the flags.
//  Sits in the arithmetic datapath beside the CLA adders.
//  Uses a valid/ready stream so it can stall behind a slow consumer.
// PARAMETERS
//  WIDTH  16  operand/result width; must be even and WIDTH/2 a multiple of 4
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block accepts beat this cycle
//  A          in   WIDTH  minuend (unsigned or two's complement)
//  B          in   WIDTH  subtrahend
//  borrowIn   in   1      borrow into bit 0
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result this cycle
//  Diff       out  WIDTH  A - B - borrowIn, mod 2^WIDTH
//  borrowOut  out  1      1 when unsigned A < B + borrowIn
//  zero       out  1      Diff == 0
//  ovf        out  1      signed overflow
// BEHAVIOUR
//  Reset (rst_n=0, async) clears state:
//   - s1_valid = out_valid = 0; Diff, borrowOut, zero, ovf = 0.
//   - Any beats in flight are discarded; no output for them after release.
//  Transfers:
//   - Input transfer on in_valid & in_ready.
//   - Output transfer on out_valid & out_ready.
//  Stage 1 register holds:
//   - low-half sum/carry from the CLA slices, with carry in = ~borrowIn;
//   - raw high halves of A and ~B;
//   - sign bits of A and B.
//  Stage 2 register (the outputs):
//   - high-half sum, with carry in = stage-1 carry;
//   - borrowOut = ~carry out of bit WIDTH-1;
//   - zero = ~|Diff;
//   - ovf = (A[msb] != B[msb]) & (Diff[msb] != A[msb]).
//  Latency:
//   - Exactly 2 cycles from an input transfer to out_valid, when not stalled.
//   - Throughput is 1 beat/cycle.
//  Advance rules:
//   - adv2 = s1_valid & (~out_valid | out_ready)
//   - in_ready = ~s1_valid | adv2  (combinational from out_ready; no skid buffer)
//  Stage 1 on each edge:
//   - loads when in_valid & in_ready;
//   - else clears s1_valid if adv2;
//   - else holds.
//  Stage 2 on each edge:
//   - loads when adv2;
//   - else clears out_valid if out_ready;
//   - else holds.
//  Stall: while out_valid & ~out_ready, Diff and flags stay stable and do not change.
//  Simultaneous consume and produce in the same cycle: both take effect. No bubble, no duplicate.
//  in_valid=0: no state change except draining.
//  Operands are sampled only on an input transfer.
//  Wrap-around: 0 - 1 gives all ones with borrowOut=1. The result is never saturated.
//  X on A/B while in_valid=0 must not propagate to the outputs.
// TESTING
//  T1 reset: rst_n=0 mid-stream with two beats in flight
//     -> out_valid=0 and all outputs 0 immediately;
//     -> no stale beat appears after release.
//  T2 basic: A=0x1234, B=0x0234, bin=0, out_ready=1
//     -> 2 cycles later Diff=0x1000, borrowOut=0, zero=0, ovf=0.
//  T3 wrap and borrow: A=0x0000, B=0x0001, bin=0 -> Diff=0xFFFF, borrowOut=1, ovf=0.
//     Then A=0x0005, B=0x0004, bin=1 -> Diff=0x0000, zero=1, borrowOut=0.
//  T4 signed overflow: A=0x8000, B=0x0001 -> Diff=0x7FFF, ovf=1.
//     Then A=0x7FFF, B=0xFFFF -> Diff=0x8000, ovf=1, borrowOut=1.
//  T5 back-pressure: stream 4 beats with out_ready=0 for 3 cycles
//     -> in_ready drops after 2 beats are held;
//     -> outputs stable while stalled;
//     -> all 4 results arrive in order, none lost or duplicated.
//  T6 random: 10k beats with random valid/ready
//     -> every result equals the reference model {borrow, A-B-bin}, with in-order scoreboard.

Source files
------------

// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined subtractor, D = A + ~B + ~borrowIn.
// 4-bit carry-lookahead slices chained through group P/G, valid/ready stream.
module cla_sub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrowIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             borrowOut,
    output logic             zero,
    output logic             ovf
);

    localparam int H  = WIDTH / 2;
    localparam int NG = H / 4;

    // Half-width add built from 4-bit lookahead slices; returns {cout, sum}.
    function automatic logic [H:0] cla_half(
        input logic [H-1:0] a,
        input logic [H-1:0] b,
        input logic         cin
    );
        logic [NG:0]  c;
        logic [H-1:0] s;
        logic [3:0]   p;
        logic [3:0]   g;
        logic [3:0]   cc;
        logic         gp;
        logic         gg;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            p     = a[4*k +: 4] ^ b[4*k +: 4];
            g     = a[4*k +: 4] & b[4*k +: 4];
            cc[0] = c[k];
            cc[1] = g[0] | (p[0] & c[k]);
            cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[k]);
            cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[k]);
            gp    = &p;
            gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
            c[k+1] = gg | (gp & c[k]);
            s[4*k +: 4] = p ^ cc;
        end
        return {c[NG], s};
    endfunction

    logic         s1_valid_q;
    logic [H-1:0] s1_lo_q;
    logic         s1_c_q;
    logic [H-1:0] s1_ahi_q;
    logic [H-1:0] s1_nbhi_q;
    logic         s1_sa_q;
    logic         s1_sb_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;
    logic             ovf_q;

    logic [H:0]       lo_sum;
    logic [H:0]       hi_sum;
    logic [WIDTH-1:0] diff_d;
    logic             adv2;
    logic             in_xfer;

    assign lo_sum  = cla_half(A[H-1:0], ~B[H-1:0], ~borrowIn);
    assign hi_sum  = cla_half(s1_ahi_q, s1_nbhi_q, s1_c_q);
    assign diff_d  = {hi_sum[H-1:0], s1_lo_q};

    assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | adv2;
    assign in_xfer  = in_valid & in_ready;

    // Stage 1: capture low-half result and raw high halves on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_c_q     <= 1'b0;
            s1_ahi_q   <= '0;
            s1_nbhi_q  <= '0;
            s1_sa_q    <= 1'b0;
            s1_sb_q    <= 1'b0;
        end else if (in_xfer) begin
            s1_valid_q <= 1'b1;
            s1_lo_q    <= lo_sum[H-1:0];
            s1_c_q     <= lo_sum[H];
            s1_ahi_q   <= A[WIDTH-1:H];
            s1_nbhi_q  <= ~B[WIDTH-1:H];
            s1_sa_q    <= A[WIDTH-1];
            s1_sb_q    <= B[WIDTH-1];
        end else if (adv2) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: resolve high half and flags; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= 1'b1;
            diff_q      <= diff_d;
            bout_q      <= ~hi_sum[H];
            zero_q      <= ~|diff_d;
            ovf_q       <= (s1_sa_q ^ s1_sb_q) & (diff_d[WIDTH-1] ^ s1_sa_q);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign borrowOut = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// tb_cla_sub_pipe: directed and random beats through cla_sub_pipe.
// Expected results are queued at input transfer and popped by a monitor.
module tb_cla_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        borrowIn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        borrowOut;
    logic        zero;
    logic        ovf;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        z;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;

    cla_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .borrowIn  (borrowIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .borrowOut (borrowOut),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present one beat until accepted; caller sits at posedge+1.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input exp_t e);
        bit hs;
        int n;
        A        = a;
        B        = b;
        borrowIn = bin;
        in_valid = 1;
        n        = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            if (hs) exp_q.push_back(e);
            @(posedge clk);
            #1;
            n++;
            if (!hs && n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck 0 expected 1");
                hs = 1;
            end
        end while (!hs);
        in_valid = 0;
        A        = 'x;
        B        = 'x;
    endtask

    task automatic sendx(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] d,
                         input logic bo, input logic z, input logic o);
        exp_t e;
        e.d = d;
        e.b = bo;
        e.z = z;
        e.o = o;
        send(a, b, bin, e);
    endtask

    task automatic sendm(input logic [15:0] a, input logic [15:0] b,
                         input logic bin);
        exp_t        e;
        logic [16:0] r;
        r   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        e.d = r[15:0];
        e.b = r[16];
        e.z = (r[15:0] == 16'd0);
        e.o = (a[15] != b[15]) && (r[15] != a[15]);
        send(a, b, bin, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats missing expected 0",
                     exp_q.size());
        end
    endtask

    // Monitor: in-order result check plus stall stability.
    initial begin
        bit          pstall;
        logic [18:0] pv;
        exp_t        e;
        pstall = 0;
        pv     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pstall = 0;
            end else begin
                if (pstall) begin
                    chk("stall_hold", {13'd0, out_valid, Diff, borrowOut,
                        zero, ovf}, {13'd0, 1'b1, pv});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: Diff=%h expected none",
                                 Diff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {13'd0, Diff, borrowOut, zero, ovf},
                            {13'd0, e.d, e.b, e.z, e.o});
                    end
                end
                pstall = out_valid && !out_ready;
                pv     = {Diff, borrowOut, zero, ovf};
            end
        end
    end

    // Random consumer for the stress phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst_n     = 0;
        in_valid  = 0;
        out_ready = 0;
        A         = '0;
        B         = '0;
        borrowIn  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {in_ready, out_valid, Diff, borrowOut, zero, ovf},
            {1'b1, 1'b0, 16'h0, 3'b000});
        rst_n = 1;
        @(posedge clk);
        #1;

        // T2 basic with latency
        out_ready = 1;
        sendx(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);
        chk("latency_c1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("latency_c2", {31'd0, out_valid}, 32'd1);
        drain();

        // T3 wrap/borrow, T4 overflow, plus extras back-to-back
        sendx(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
        sendx(16'h0005, 16'h0004, 1, 16'h0000, 0, 1, 0);
        sendx(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 0, 1);
        sendx(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 0, 1);
        sendx(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0);
        sendx(16'h00F0, 16'h000F, 0, 16'h00E1, 0, 0, 0);
        sendx(16'h0100, 16'h0001, 1, 16'h00FE, 0, 0, 0);
        drain();

        // T5 back-pressure
        out_ready = 0;
        fork
            begin
                sendx(16'h0010, 16'h0001, 0, 16'h000F, 0, 0, 0);
                sendx(16'h0020, 16'h0020, 0, 16'h0000, 0, 1, 0);
                sendx(16'h0001, 16'h0002, 0, 16'hFFFF, 1, 0, 0);
                sendx(16'h8000, 16'h7FFF, 1, 16'h0000, 0, 1, 1);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", {30'd0, in_ready, out_valid}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();

        // T1 reset with two beats in flight
        out_ready = 0;
        sendx(16'h1111, 16'h0001, 0, 16'h1110, 0, 0, 0);
        sendx(16'h2222, 16'h0002, 0, 16'h2220, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("rst_async", {in_ready, out_valid, Diff, borrowOut, zero, ovf},
            {1'b1, 1'b0, 16'h0, 3'b000});
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1;
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_stale", {31'd0, out_valid}, 32'd0);

        // T6 random valid/ready
        rand_ready = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            sendm(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_ready = 0;
        out_ready  = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
